systolic_array_ws: RTL
======================

# systolic_array_ws

Parametrised weight-stationary systolic matrix-vector engine: ROWS×COLS grid of signed MAC processing elements computing y[c] = Σr a[r]·W[r][c] for a stream of activation vectors against a resident weight matrix. Generalises the fixed systolic_array to arbitrary grid size and data/accumulator widths. Adds ready/valid handshakes with global backpressure stall, batch framing, and optional saturating accumulation. Sits between the activation buffer (upstream) and the result writer (downstream).

## Interface
- ROWS, 4, grid rows = activation vector length (≥2)
- COLS, 4, grid columns = weight/result vector length (≥2)
- DATA_W, 8, signed weight/activation width
- ACC_W, 24, signed accumulator/result width (≥2·DATA_W)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_valid  in  1  weight row beat valid
- w_ready  out  1  weight row beat accepted when both high
- w_data  in  COLS·DATA_W  one weight row, element c at bits [c·DATA_W +: DATA_W]
- a_valid  in  1  activation vector valid
- a_ready  out  1  activation vector accepted when both high
- a_data  in  ROWS·DATA_W  activation vector, element r at [r·DATA_W +: DATA_W]
- a_last  in  1  final vector of batch, sampled with a beat
- y_valid  out  1  result vector valid
- y_ready  in  1  result consumed when both high
- y_data  out  COLS·ACC_W  result vector, element c at [c·ACC_W +: ACC_W]
- y_last  out  1  result belongs to the a_last vector
- busy  out  1  state ≠ IDLE or any vector in flight

## Operation
- FSM states IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: w_ready=1; a_ready = wts_loaded & !w_valid & en. Accepted w beat → LOAD_W (row 0 written, row counter=1). Accepted a beat → STREAM, or DRAIN if a_last.
- LOAD_W: w_ready=1, a_ready=0. Each beat writes row counter's row; after row ROWS-1, set wts_loaded → IDLE. Reloading overwrites all rows.
- STREAM: a_ready=en, w_ready=0. Beat with a_last → DRAIN.
- DRAIN: a_ready=w_ready=0. When pipeline empty and y_valid=0 → IDLE.
- Weights persist across batches until reload or reset.
- en = !(y_valid & !y_ready). When en=0, every pipeline register (input skew, PE, deskew, valid/last shift) holds.
- Input row r skewed by r stages. Partial sums flow down, activations flow right. Column c deskewed by COLS-1-c stages. Final output register feeds y_*.
- Valid and last bits travel in a LAT-deep shift chain in lockstep with data.
- Arithmetic: DATA_W×DATA_W signed product, sign-extended to ACC_W. Add wraps modulo 2^ACC_W (see Configuration).

## Timing
- Reset (rst high at an edge): state=IDLE, W=0, wts_loaded=0, pipeline cleared. All outputs 0 while rst high. From the first cycle after rst deasserts: w_ready=1, a_ready=0, y_valid=0, y_last=0, y_data=0, busy=0.
- Latency LAT = ROWS+COLS enabled cycles: a beat accepted at edge k yields y_valid high after edge k+LAT when never stalled.
- Throughput: one vector per cycle in STREAM with y_ready=1.
- Stall: a stalled cycle adds one cycle of latency. No loss, no duplication.
- y_data/y_last stable while y_valid & !y_ready.
- Reset mid-operation discards all in-flight vectors and weights. y_valid is 0 after the reset edge.
- Simultaneous w_valid and a_valid in IDLE: weight beat wins.

## Configuration
- SYSTOLIC_ARRAY_SAT_EN defined: every PE add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- SYSTOLIC_ARRAY_SAT_EN undefined: two's-complement wrap.

## Structure
- Package systolic_pkg: state_t enum (IDLE, LOAD_W, STREAM, DRAIN), default ROWS/COLS/DATA_W/ACC_W constants, sat_add function.
- Sub-module systolic_pe:
  - weight register with write enable
  - activation pass-right register
  - psum pass-down register
  - global en input
- Top level instantiates ROWS×COLS PEs via generate.

## Test plan
- Reset: rst high 2 cycles → next cycle w_ready=1, a_ready=0, y_valid=0, busy=0.
- Identity W, a=[1,2,3,4] with a_last → y=[1,2,3,4], y_last=1, y_valid exactly 8 cycles after accept. Then IDLE, busy=0.
- All-ones W; back-to-back a=[-1,-2,-3,-4], [127×4], [-128×4] (last) → y cols -10, 508, -512 on consecutive cycles. y_last only on third.
- Backpressure: 6-vector stream, y_ready low 5 cycles mid-stream → a_ready low while stalled. All 6 results in order, each exactly once.
- ACC_W=16, W=127 all, a=127 all → 64516 overflows. Result 32767 with SYSTOLIC_ARRAY_SAT_EN; -1020 without.
- rst asserted with 2 vectors in flight → no y_valid afterward. a_ready=0 until a full ROWS-beat reload completes.

Source files
------------

// File: rtl/systolic_array_ws_pkg.sv
// systolic_pkg: shared types, default sizes and arithmetic helpers for the
// weight-stationary systolic matrix-vector engine (systolic_array_ws).
//   state_t   - controller states IDLE / LOAD_W / STREAM / DRAIN
//   *_DEF     - default grid and datapath sizes
//   sat_add   - signed add clamped to a w-bit two's-complement range
//               (used by the PEs when SYSTOLIC_ARRAY_SAT_EN is defined)
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int unsigned ROWS_DEF   = 4;
    localparam int unsigned COLS_DEF   = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 24;

    // Operands are sign-extended w-bit values (w <= 63); the 65-bit sum
    // cannot overflow, so the clamp is exact.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                   input logic signed [63:0] y,
                                                   input int unsigned        w);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = 65'(x) + 65'(y);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi)
            return 64'(hi);
        else if (s < lo)
            return 64'(lo);
        return 64'(s);
    endfunction

endpackage

// File: rtl/systolic_array_ws_pe.sv
// systolic_pe: one signed MAC processing element of the weight-stationary grid.
// Holds a resident weight, forwards its activation to the right and its
// updated partial sum downward, one register stage each.
// Optional feature macro: SYSTOLIC_ARRAY_SAT_EN (saturating accumulate),
// otherwise the accumulate wraps modulo 2^ACC_W.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - global advance enable (low = hold all pipeline state)
//   w_we, w_in - weight write enable / value (not gated by en)
//   a_in/a_out - activation in from the left / registered out to the right
//   psum_in    - partial sum from the PE above (0 for the top row)
//   psum_out   - registered partial sum to the PE below
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     w_we,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [ACC_W-1:0]  psum_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [ACC_W-1:0]  psum_out
);

    logic signed [DATA_W-1:0]   w_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    psum_next;

    always_comb begin
        prod     = (2*DATA_W)'(a_in) * (2*DATA_W)'(w_q);
        prod_ext = ACC_W'(prod);
`ifdef SYSTOLIC_ARRAY_SAT_EN
        psum_next = ACC_W'(sat_add(64'(psum_in), 64'(prod_ext), ACC_W));
`else
        psum_next = psum_in + prod_ext;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q      <= '0;
            a_out    <= '0;
            psum_out <= '0;
        end else begin
            if (w_we)
                w_q <= w_in;
            if (en) begin
                a_out    <= a_in;
                psum_out <= psum_next;
            end
        end
    end

endmodule

// File: rtl/systolic_array_ws.sv
// systolic_array_ws: parametrised weight-stationary systolic matrix-vector
// engine computing y[c] = sum_r a[r]*W[r][c] for a stream of activation
// vectors against a resident ROWSxCOLS weight matrix.
// Optional feature macro: SYSTOLIC_ARRAY_SAT_EN (saturating PE accumulate).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   w_valid/w_ready/w_data   - weight row beats, rows written 0..ROWS-1
//   a_valid/a_ready/a_data   - activation vectors; a_last closes a batch
//   y_valid/y_ready/y_data   - result vectors; y_last marks the a_last result
//   busy                     - controller not idle or vectors in flight
// Latency is ROWS+COLS enabled cycles; a held result (y_valid & !y_ready)
// freezes the whole pipeline.
module systolic_array_ws
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*DATA_W-1:0] w_data,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ROWS*DATA_W-1:0] a_data,
    input  logic                   a_last,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [COLS*ACC_W-1:0]  y_data,
    output logic                   y_last,
    output logic                   busy
);

    localparam int unsigned LAT  = ROWS + COLS;
    localparam int unsigned RC_W = $clog2(ROWS);

    state_t            state;
    logic [RC_W-1:0]   row_cnt;
    logic [RC_W-1:0]   wr_row;
    logic              wts_loaded;
    logic              en;
    logic              w_fire;
    logic              a_fire;
    logic              pipe_busy;
    logic [ROWS-1:0]   w_we;
    // Bit 0 is the input stage; bit LAT is the output register.
    logic [LAT:0]      vld_sh;
    logic [LAT:0]      last_sh;

    logic signed [DATA_W-1:0] row_a   [ROWS];
    logic signed [DATA_W-1:0] a_pipe  [ROWS][COLS];
    logic signed [ACC_W-1:0]  psum    [ROWS][COLS];
    logic signed [ACC_W-1:0]  col_out [COLS];

    // ---------------- handshakes and status ----------------
    assign en        = !(vld_sh[LAT] && !y_ready);
    assign pipe_busy = |vld_sh;
    assign w_ready   = !rst && (state == IDLE || state == LOAD_W);
    assign a_ready   = !rst && en &&
                       ((state == IDLE && wts_loaded && !w_valid) || state == STREAM);
    assign w_fire    = w_valid && w_ready;
    assign a_fire    = a_valid && a_ready;
    assign y_valid   = !rst && vld_sh[LAT];
    assign y_last    = !rst && last_sh[LAT];
    assign busy      = !rst && (state != IDLE || pipe_busy);

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            wts_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_fire) begin
                        state   <= LOAD_W;
                        row_cnt <= RC_W'(1);
                    end else if (a_fire) begin
                        state <= a_last ? DRAIN : STREAM;
                    end
                end
                LOAD_W: begin
                    if (w_fire) begin
                        if (row_cnt == RC_W'(ROWS - 1)) begin
                            state      <= IDLE;
                            row_cnt    <= '0;
                            wts_loaded <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + RC_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (a_fire && a_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!pipe_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The first beat of a load is taken in IDLE and always targets row 0.
    assign wr_row = (state == LOAD_W) ? row_cnt : '0;

    // ---------------- valid / last tracking ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sh  <= '0;
            last_sh <= '0;
        end else if (en) begin
            vld_sh  <= {vld_sh[LAT-1:0], a_fire};
            last_sh <= {last_sh[LAT-1:0], a_fire && a_last};
        end
    end

    // ---------------- input register + row skew ----------------
    // Row r sees its element r+1 registers after the accept edge; bubbles
    // inject zero activations so idle wavefronts carry zero sums.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic signed [DATA_W-1:0] sk [0:r];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i <= r; i++)
                    sk[i] <= '0;
            end else if (en) begin
                sk[0] <= a_fire ? a_data[r*DATA_W +: DATA_W] : '0;
                for (int unsigned i = 1; i <= r; i++)
                    sk[i] <= sk[i-1];
            end
        end
        assign row_a[r] = sk[r];
        assign w_we[r]  = w_fire && (wr_row == RC_W'(r));
    end

    // ---------------- PE grid ----------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [DATA_W-1:0] a_in_w;
            logic signed [ACC_W-1:0]  p_in_w;

            if (c == 0) begin : g_a_edge
                assign a_in_w = row_a[r];
            end else begin : g_a_int
                assign a_in_w = a_pipe[r][c-1];
            end

            if (r == 0) begin : g_p_edge
                assign p_in_w = '0;
            end else begin : g_p_int
                assign p_in_w = psum[r-1][c];
            end

            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .w_we     (w_we[r]),
                .w_in     (w_data[c*DATA_W +: DATA_W]),
                .a_in     (a_in_w),
                .psum_in  (p_in_w),
                .a_out    (a_pipe[r][c]),
                .psum_out (psum[r][c])
            );
        end
    end

    // ---------------- column deskew + output register ----------------
    for (genvar c = 0; c < COLS; c++) begin : g_desk
        localparam int unsigned D = COLS - 1 - c;
        logic signed [ACC_W-1:0] yq;

        if (D == 0) begin : g_direct
            assign col_out[c] = psum[ROWS-1][c];
        end else begin : g_delay
            logic signed [ACC_W-1:0] dq [0:D-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < D; i++)
                        dq[i] <= '0;
                end else if (en) begin
                    dq[0] <= psum[ROWS-1][c];
                    for (int unsigned i = 1; i < D; i++)
                        dq[i] <= dq[i-1];
                end
            end
            assign col_out[c] = dq[D-1];
        end

        always_ff @(posedge clk) begin
            if (rst)
                yq <= '0;
            else if (en)
                yq <= col_out[c];
        end

        assign y_data[c*ACC_W +: ACC_W] = rst ? '0 : yq;
    end

endmodule
